prog_loader: RTL and testbench

- Writer side of the instruction memory: receives a program as a byte stream from the UART receiver, packs it into 32-bit words and writes them sequentially into the instruction ROM/RAM write port.
- The fetch unit reads the same memory using word address pc[15:2].
- Holds the CPU core in reset while loading, then releases it so execution starts at pc = 0.
- End of program is detected by an inter-byte idle timeout or by memory full.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/prog_loader_word_packer.sv | 54 +++++
 rtl/prog_loader.sv | 124 ++++++++++++
 tb/tb_prog_loader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the program loader: FSM encoding, word geometry and
// the default idle timeout for the board's UART baud rate.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int BYTES_PER_WORD      = 4;
  localparam int BYTE_IDX_W          = $clog2(BYTES_PER_WORD);
  localparam int DEFAULT_TIMEOUT_CYC = 1000000;

endpackage

// File: rtl/prog_loader_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words and keeps the running
// mod-256 checksum; word_ready fires combinationally with the last lane byte.
module word_packer
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [7:0]            data,
  output logic                  word_ready,
  output logic [31:0]           word,
  output logic [BYTE_IDX_W-1:0] byte_idx,
  output logic [7:0]            checksum
);

  logic [BYTE_IDX_W-1:0] idx_reg;
  logic [7:0]            sum_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg <= '0;
      sum_reg <= '0;
    end else if (clear) begin
      idx_reg <= '0;
      sum_reg <= '0;
    end else if (accept) begin
      idx_reg <= idx_reg + 1'b1;
      sum_reg <= sum_reg + data;
    end
  end

  // The lane being filled this cycle is bypassed so the full word is
  // available on the same edge that accepts its last byte.
  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      logic [7:0] lane_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          lane_reg <= '0;
        else if (accept && idx_reg == BYTE_IDX_W'(gi))
          lane_reg <= data;
      end

      assign word[gi*8 +: 8] = (idx_reg == BYTE_IDX_W'(gi)) ? data : lane_reg;
    end
  endgenerate

  assign word_ready = accept && (idx_reg == BYTE_IDX_W'(BYTES_PER_WORD - 1));
  assign byte_idx   = idx_reg;
  assign checksum   = sum_reg;

endmodule

// File: rtl/prog_loader.sv
// Loads a UART byte stream into instruction memory as sequential 32-bit words,
// holding the CPU in reset until an idle timeout or memory full ends the load.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count,
  output logic [7:0]        checksum
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      idle_reg;
  logic                  first_reg;
  logic                  err_reg;
  logic                  wr_en_reg;
  logic [ADDR_W-1:0]     wr_addr_reg;
  logic [31:0]           wr_data_reg;
  logic                  hold_reg, busy_reg, done_reg;
  logic [ADDR_W:0]       count_reg;

  logic                  load_start, accept, timeout, last_word;
  logic                  word_ready;
  logic [31:0]           word;
  logic [BYTE_IDX_W-1:0] byte_idx;

  assign load_start = (state_reg == ST_IDLE) && start;
  assign accept     = (state_reg == ST_LOAD) && rx_valid;
  assign timeout    = (state_reg == ST_LOAD) && first_reg && !rx_valid &&
                      (idle_reg == CNT_W'(TIMEOUT_CYC - 1));
  // The low count bits double as the next write address.
  assign last_word  = word_ready && (count_reg[ADDR_W-1:0] == {ADDR_W{1'b1}});

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (load_start),
    .accept     (accept),
    .data       (rx_data),
    .word_ready (word_ready),
    .word       (word),
    .byte_idx   (byte_idx),
    .checksum   (checksum)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_LOAD;
      ST_LOAD: if (timeout || last_word) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      idle_reg    <= '0;
      first_reg   <= 1'b0;
      err_reg     <= 1'b0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      hold_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= (state_next != ST_IDLE);
      busy_reg  <= (state_next != ST_IDLE);
      done_reg  <= (state_next == ST_DONE);
      wr_en_reg <= word_ready;

      if (word_ready) begin
        wr_data_reg <= word;
        wr_addr_reg <= count_reg[ADDR_W-1:0];
        count_reg   <= count_reg + 1'b1;
      end

      if (load_start) begin
        count_reg <= '0;
        err_reg   <= 1'b0;
        first_reg <= 1'b0;
        idle_reg  <= '0;
      end else if (accept) begin
        first_reg <= 1'b1;
        idle_reg  <= '0;
      end else if (state_reg == ST_LOAD && first_reg) begin
        idle_reg <= idle_reg + 1'b1;
      end

      // A half-assembled word at timeout is dropped and flagged.
      if (timeout && byte_idx != '0)
        err_reg <= 1'b1;
    end
  end

  assign wr_en      = wr_en_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign cpu_hold   = hold_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign word_count = count_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with ADDR_W=4, TIMEOUT_CYC=16: write log from
// a negedge monitor, expectations hand-computed in the stimulus sequence.
module tb_prog_loader;

    localparam int ADDR_W = 4;
    localparam int TO     = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold, busy, done, err;
    logic [ADDR_W:0]   word_count;
    logic [7:0]        checksum;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;

    logic [ADDR_W-1:0] wa[$];
    logic [31:0]       wd[$];
    int                wc[$];

    prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
            wc.push_back(cyc);
            $display("write: addr=%0d data=%08h edge=%0d", wr_addr, wr_data, cyc);
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input bit pass,
                       input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (!pass) begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output int e);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        e = cyc;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    initial begin
        int e, e3, e7, e0, dbase;
        bit ok;
        logic [31:0] expw;

        // 1: reset state, then asynchronous reset in the middle of a load
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {wr_en, wr_addr, wr_data, cpu_hold, busy, done, err, word_count, checksum} === 55'd0,
            {wr_en, wr_addr, wr_data, cpu_hold, busy, done, err, word_count, checksum}, 55'd0);
        rst = 1'b1;
        tick();
        pulse_start();
        send_byte(8'h11, e);
        send_byte(8'h22, e);
        send_byte(8'h33, e);
        send_byte(8'h44, e);
        chk("pre_reset_wr_en", wr_en === 1'b1, wr_en, 1'b1);
        chk("pre_reset_checksum", checksum === 8'hAA, checksum, 8'hAA);
        rst = 1'b0;
        #1;
        chk("async_reset_wr_en", wr_en === 1'b0, wr_en, 1'b0);
        chk("async_reset_hold", cpu_hold === 1'b0, cpu_hold, 1'b0);
        chk("async_reset_all", {wr_en, wr_addr, wr_data, cpu_hold, busy, done, err, word_count, checksum} === 55'd0,
            {wr_en, wr_addr, wr_data, cpu_hold, busy, done, err, word_count, checksum}, 55'd0);
        rst = 1'b1;
        tick();
        chk("post_reset_idle", {cpu_hold, busy, done} === 3'b000, {cpu_hold, busy, done}, 3'b000);
        $display("test1: async reset mid-load");

        // 2: two words with 10-cycle byte spacing
        clear_log();
        dbase = done_cnt;
        pulse_start();
        chk("t2_load_hold", {cpu_hold, busy} === 2'b11, {cpu_hold, busy}, 2'b11);
        begin
            logic [7:0] prog [8];
            prog = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
            e3 = 0;
            e7 = 0;
            for (int i = 0; i < 8; i++) begin
                send_byte(prog[i], e);
                if (i == 3) e3 = e;
                if (i == 7) e7 = e;
                if (i != 7) repeat (9) tick();
            end
        end
        wait_done(ok);
        chk("t2_done_seen", ok === 1'b1, ok, 1'b1);
        chk("t2_done_edge", cyc === e7 + TO, cyc, e7 + TO);
        chk("t2_word_count", word_count === 5'd2, word_count, 5'd2);
        chk("t2_checksum", checksum === 8'hD6, checksum, 8'hD6);
        chk("t2_err", err === 1'b0, err, 1'b0);
        chk("t2_done_hold", {cpu_hold, busy} === 2'b11, {cpu_hold, busy}, 2'b11);
        tick();
        chk("t2_release", {cpu_hold, busy, done} === 3'b000, {cpu_hold, busy, done}, 3'b000);
        chk("t2_done_pulses", done_cnt - dbase === 1, done_cnt - dbase, 1);
        chk("t2_nwrites", wa.size() === 2, wa.size(), 2);
        chk("t2_w0_addr", wa[0] === 4'd0, wa[0], 4'd0);
        chk("t2_w0_data", wd[0] === 32'h00100013, wd[0], 32'h00100013);
        chk("t2_w0_edge", wc[0] === e3, wc[0], e3);
        chk("t2_w1_addr", wa[1] === 4'd1, wa[1], 4'd1);
        chk("t2_w1_data", wd[1] === 32'h00200093, wd[1], 32'h00200093);
        chk("t2_w1_edge", wc[1] === e7, wc[1], e7);
        $display("test2: two-word load");

        // 3: one word plus two stray bytes ends with err
        clear_log();
        pulse_start();
        for (int i = 1; i <= 6; i++) send_byte(8'(i), e);
        wait_done(ok);
        chk("t3_done_seen", ok === 1'b1, ok, 1'b1);
        chk("t3_done_edge", cyc === e + TO, cyc, e + TO);
        chk("t3_err", err === 1'b1, err, 1'b1);
        chk("t3_word_count", word_count === 5'd1, word_count, 5'd1);
        chk("t3_checksum", checksum === 8'h15, checksum, 8'h15);
        tick();
        chk("t3_nwrites", wa.size() === 1, wa.size(), 1);
        chk("t3_w0_addr", wa[0] === 4'd0, wa[0], 4'd0);
        chk("t3_w0_data", wd[0] === 32'h04030201, wd[0], 32'h04030201);
        chk("t3_err_sticky", {err, busy} === 2'b10, {err, busy}, 2'b10);
        $display("test3: partial word timeout");

        // 4: fill memory back-to-back
        clear_log();
        pulse_start();
        chk("t4_err_cleared", err === 1'b0, err, 1'b0);
        chk("t4_count_cleared", word_count === 5'd0, word_count, 5'd0);
        e0 = 0;
        rx_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            rx_data = 8'(i);
            tick();
            if (i == 0) e0 = cyc;
        end
        chk("t4_done_with_last", {done, wr_en} === 2'b11, {done, wr_en}, 2'b11);
        chk("t4_last_addr", wr_addr === 4'd15, wr_addr, 4'd15);
        chk("t4_last_data", wr_data === 32'h3F3E3D3C, wr_data, 32'h3F3E3D3C);
        chk("t4_word_count", word_count === 5'd16, word_count, 5'd16);
        chk("t4_err", err === 1'b0, err, 1'b0);
        rx_data = 8'hFF;
        tick();
        rx_valid = 1'b0;
        chk("t4_checksum_after_extra", checksum === 8'hE0, checksum, 8'hE0);
        chk("t4_idle", {busy, wr_en} === 2'b00, {busy, wr_en}, 2'b00);
        chk("t4_nwrites", wa.size() === 16, wa.size(), 16);
        for (int k = 0; k < 16; k++) begin
            expw = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            chk("t4_addr", wa[k] === 4'(k), wa[k], 4'(k));
            chk("t4_data", wd[k] === expw, wd[k], expw);
            chk("t4_edge", wc[k] === e0 + 4*k + 3, wc[k], e0 + 4*k + 3);
        end
        $display("test4: memory full");

        // 5: no timeout before the first byte
        clear_log();
        dbase = done_cnt;
        pulse_start();
        repeat (100) tick();
        chk("t5_still_loading", {cpu_hold, busy, done} === 3'b110, {cpu_hold, busy, done}, 3'b110);
        chk("t5_no_done", done_cnt - dbase === 0, done_cnt - dbase, 0);
        send_byte(8'hAA, e);
        send_byte(8'hBB, e);
        send_byte(8'hCC, e);
        send_byte(8'hDD, e);
        wait_done(ok);
        chk("t5_done_seen", ok === 1'b1, ok, 1'b1);
        chk("t5_done_edge", cyc === e + TO, cyc, e + TO);
        chk("t5_err", err === 1'b0, err, 1'b0);
        chk("t5_word_count", word_count === 5'd1, word_count, 5'd1);
        chk("t5_checksum", checksum === 8'h0E, checksum, 8'h0E);
        tick();
        chk("t5_nwrites", wa.size() === 1, wa.size(), 1);
        chk("t5_w0", {wa[0], wd[0]} === {4'd0, 32'hDDCCBBAA}, {wa[0], wd[0]}, {4'd0, 32'hDDCCBBAA});
        chk("t5_w0_edge", wc[0] === e, wc[0], e);
        $display("test5: wait for first byte");

        // 6: rx_valid in IDLE and start in LOAD are ignored
        clear_log();
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'h55;
            tick();
            rx_valid = 1'b0;
            tick();
        end
        chk("t6_idle_checksum", checksum === 8'h0E, checksum, 8'h0E);
        chk("t6_idle_count", word_count === 5'd1, word_count, 5'd1);
        chk("t6_idle_state", busy === 1'b0, busy, 1'b0);
        chk("t6_idle_nwrites", wa.size() === 0, wa.size(), 0);
        pulse_start();
        send_byte(8'h05, e);
        tick();
        pulse_start();
        chk("t6_load_state", {busy, done} === 2'b10, {busy, done}, 2'b10);
        chk("t6_load_checksum", checksum === 8'h05, checksum, 8'h05);
        wait_done(ok);
        chk("t6_done_seen", ok === 1'b1, ok, 1'b1);
        chk("t6_done_edge", cyc === e + TO, cyc, e + TO);
        chk("t6_err", err === 1'b1, err, 1'b1);
        chk("t6_word_count", word_count === 5'd0, word_count, 5'd0);
        tick();
        chk("t6_nwrites", wa.size() === 0, wa.size(), 0);
        $display("test6: ignored start and rx_valid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
